fifo_pop_stream: RTL and testbench

Read-side front end for the team's synchronous `fifo`. It issues `pop` against the FIFO and absorbs the FIFO's one-cycle read latency. It delivers the words in order on a valid/ready output stream, with no bubbles at full rate and no loss under backpressure. It sits between the FIFO's `pop`/`data_out` pins and any downstream consumer, which replaces ad-hoc pop logic in consumers.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_skid2.sv | 69 ++++++
 rtl/fifo_pop_stream.sv | 61 ++++++
 tb/tb_fifo_pop_stream.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side front end.
package fifo_pkg;

  localparam int LP_SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry in-order register buffer: head drives the output, skid catches
// the word that arrives while the head is stalled.
//
// state | meaning
// EMPTY | no word held, head is stale
// ONE   | head holds the oldest word
// TWO   | head holds the oldest word, skid holds the next one
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       level_o,
  output logic             valid_o
);

  buf_state_e       state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_i) begin
            head_q  <= push_data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push_i && pop_i) begin
            head_q <= push_data_i;
          end else if (push_i) begin
            skid_q  <= push_data_i;
            state_q <= TWO;
          end else if (pop_i) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (pop_i) begin
            head_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign head_o  = head_q;
  assign level_o = state_q;
  assign valid_o = (state_q != EMPTY);

  // The upstream credit check guarantees a full buffer never sees a push.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && state_q == TWO));

endmodule

// File: rtl/fifo_pop_stream.sv
// Pops the synchronous FIFO against buffer credit and presents the words on
// a valid/ready stream, hiding the FIFO's one-cycle read latency.
module fifo_pop_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       level
);

  localparam logic [2:0] LP_CAP = 3'(LP_SKID_DEPTH);

  logic       inflight_q;
  logic       inflight_d;
  logic       en_q;
  logic       deq;
  logic [2:0] credit;

  assign deq = m_valid && m_ready;

  // Occupancy after this cycle's dequeue; a word leaving frees a slot for
  // the pop issued now, which is what sustains one word per cycle.
  assign credit = {1'b0, level} + {2'b0, inflight_q} - {2'b0, deq};

  // en_q keeps the pop strobe low throughout reset without routing rst_n
  // into the combinational path.
  assign fifo_pop   = en_q && !fifo_empty && (credit < LP_CAP);
  assign inflight_d = fifo_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      en_q       <= 1'b1;
    end
  end

  fifo_skid2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i(fifo_data),
    .pop_i      (deq),
    .head_o     (m_data),
    .level_o    (level),
    .valid_o    (m_valid)
  );

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed bench for fifo_pop_stream with a behavioural FIFO on the pop side.
module tb_fifo_pop_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [31:0] fifo_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [1:0]  level;

  logic        fake_nonempty = 1'b1;
  logic [31:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          load_n;
    logic [31:0] load_base;
    logic        rdy;
    logic        pop;
    logic        valid;
    logic [31:0] data;
    logic [1:0]  lvl;
  } vec_t;

  vec_t tbl [19];

  fifo_pop_stream #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .fifo_data (fifo_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .level     (level)
  );

  always #5 clk = ~clk;

  // FIFO model: shares rst_n, data appears the cycle after a pop.
  assign fifo_empty = (rd_ptr == wr_ptr) && !fake_nonempty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (fifo_pop && rd_ptr != wr_ptr) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + 32'(i);
      wr_ptr++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          got;
    logic [31:0] exp_d;

    tbl[0]  = '{4, 32'hA0, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0};
    tbl[1]  = '{0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0};
    tbl[2]  = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA0, 2'd1};
    tbl[3]  = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA1, 2'd1};
    tbl[4]  = '{0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1};
    tbl[5]  = '{0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA3, 2'd1};
    tbl[6]  = '{0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0};
    tbl[7]  = '{6, 32'hB0, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
    tbl[8]  = '{0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
    tbl[9]  = '{0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hB0, 2'd1};
    tbl[10] = '{0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hB0, 2'd2};
    tbl[11] = '{0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hB0, 2'd2};
    tbl[12] = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB0, 2'd2};
    tbl[13] = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB1, 2'd1};
    tbl[14] = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB2, 2'd1};
    tbl[15] = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB3, 2'd1};
    tbl[16] = '{0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hB4, 2'd1};
    tbl[17] = '{0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hB5, 2'd1};
    tbl[18] = '{0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0};

    // Reset held with a non-empty FIFO: nothing may be popped.
    repeat (3) begin
      tick();
      check("rst_pop", 32'(fifo_pop), 32'h0);
      check("rst_valid", 32'(m_valid), 32'h0);
      check("rst_level", 32'(level), 32'h0);
      check("rst_data", m_data, 32'h0);
    end
    rst_n = 1'b1;
    fake_nonempty = 1'b0;
    tick();
    check("idle_pop", 32'(fifo_pop), 32'h0);

    // Full rate, then backpressure and release.
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].load_n > 0) load(tbl[i].load_n, tbl[i].load_base);
      m_ready = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d_pop", i), 32'(fifo_pop), 32'(tbl[i].pop));
      check($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      if (tbl[i].valid) check($sformatf("tbl%0d_data", i), m_data, tbl[i].data);
      tick();
    end

    // Empty FIFO stays quiet, then a single word trickles through.
    m_ready = 1'b1;
    repeat (10) begin
      #1;
      check("empty_pop", 32'(fifo_pop), 32'h0);
      check("empty_valid", 32'(m_valid), 32'h0);
      tick();
    end
    load(1, 32'hC0);
    #1;
    check("c0_pop", 32'(fifo_pop), 32'h1);
    tick();
    check("c1_pop", 32'(fifo_pop), 32'h0);
    check("c1_valid", 32'(m_valid), 32'h0);
    tick();
    check("c2_valid", 32'(m_valid), 32'h1);
    check("c2_data", m_data, 32'hC0);
    tick();
    check("c3_valid", 32'(m_valid), 32'h0);

    // Alternating ready over eight words.
    load(8, 32'hD0);
    got = 0;
    exp_d = 32'hD0;
    for (int k = 0; k < 60 && got < 8; k++) begin
      m_ready = (k % 2 == 0);
      #1;
      check("alt_level_max", 32'(level <= 2'd2), 32'h1);
      if (m_valid && m_ready) begin
        check("alt_data", m_data, exp_d);
        exp_d++;
        got++;
      end
      tick();
    end
    check("alt_count", 32'(got), 32'h8);

    // Reset while a word is in flight and the buffer holds its credit.
    m_ready = 1'b0;
    load(6, 32'hE0);
    #1;
    check("mr_pop0", 32'(fifo_pop), 32'h1);
    tick();
    tick();
    check("mr_level", 32'(level), 32'h1);
    check("mr_pop_blocked", 32'(fifo_pop), 32'h0);
    check("mr_data", m_data, 32'hE0);
    rst_n = 1'b0;
    #1;
    check("mr_rst_pop", 32'(fifo_pop), 32'h0);
    check("mr_rst_valid", 32'(m_valid), 32'h0);
    check("mr_rst_level", 32'(level), 32'h0);
    check("mr_rst_data", m_data, 32'h0);
    tick();
    check("mr_hold_pop", 32'(fifo_pop), 32'h0);
    rst_n = 1'b1;
    tick();
    load(2, 32'hF0);
    m_ready = 1'b1;
    got = 0;
    exp_d = 32'hF0;
    for (int k = 0; k < 20 && got < 2; k++) begin
      #1;
      if (m_valid) begin
        check("fresh_data", m_data, exp_d);
        exp_d++;
        got++;
      end
      tick();
    end
    check("fresh_count", 32'(got), 32'h2);
    #1;
    check("fresh_drained", 32'(m_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
